bp_be_ctxt_switch_ctrl: RTL and testbench

- Sequences backend thread context switches: drain pipeline, save outgoing context, redirect FE to incoming thread's NPC, resume issue.
- Triggers: timeslice quantum expiry (round-robin over enabled threads) or CSR-requested switch.
- Sits between the backend pipeline (director/scheduler idle status, commit) and per-thread context storage.
- Drives the current thread ID consumed by context storage and the calculator.

---
 rtl/bp_be_pkg.sv | 12 +
 rtl/bp_be_ctxt_rr_pick.sv | 37 +++
 rtl/bp_be_ctxt_switch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bp_be_ctxt_switch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the backend context-switch controller.
package bp_be_pkg;

    typedef enum logic [2:0] {
        e_run,
        e_drain,
        e_save,
        e_redirect,
        e_resume
    } bp_be_ctxt_sw_state_e;

endpackage

// File: rtl/bp_be_ctxt_rr_pick.sv
// Round-robin picker: returns the first enabled thread after cur_tid_i, wrapping
// around and considering cur_tid_i itself last.
module bp_be_ctxt_rr_pick #(
    parameter int num_threads_p     = 4,
    parameter int thread_id_width_p = $clog2(num_threads_p)
) (
    input  logic [thread_id_width_p-1:0] cur_tid_i,
    input  logic [num_threads_p-1:0]     en_i,
    output logic [thread_id_width_p-1:0] next_tid_o,
    output logic                         found_o
);

    logic                         w_found;
    logic [thread_id_width_p-1:0] w_next;
    logic [thread_id_width_p-1:0] w_idx;
    int                           w_sum;

    always_comb begin
        w_found = 1'b0;
        w_next  = cur_tid_i;
        w_idx   = '0;
        w_sum   = 0;
        for (int i = 1; i <= num_threads_p; i++) begin
            w_sum = int'(cur_tid_i) + i;
            if (w_sum >= num_threads_p) w_sum = w_sum - num_threads_p;
            w_idx = thread_id_width_p'(w_sum);
            if (!w_found && en_i[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    assign next_tid_o = w_next;
    assign found_o    = w_found;

endmodule

// File: rtl/bp_be_ctxt_switch_ctrl.sv
// Backend context-switch sequencer: drain, save, redirect FE, resume.
// Optional drain watchdog enabled by defining BP_BE_CTXT_DRAIN_TIMEOUT_EN.
module bp_be_ctxt_switch_ctrl
    import bp_be_pkg::*;
#(
    parameter int num_threads_p     = 4,
    parameter int thread_id_width_p = $clog2(num_threads_p),
    parameter int vaddr_width_p     = 39,
    parameter int quantum_width_p   = 16
`ifdef BP_BE_CTXT_DRAIN_TIMEOUT_EN
    , parameter int drain_timeout_width_p = 8
`endif
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [quantum_width_p-1:0]   quantum_i,
    input  logic [num_threads_p-1:0]     thread_en_i,
    input  logic                         csr_switch_v_i,
    input  logic [thread_id_width_p-1:0] csr_switch_tid_i,
    output logic                         csr_switch_ready_o,
    input  logic                         pipe_idle_i,
    input  logic [vaddr_width_p-1:0]     ctx_npc_i,
    output logic [thread_id_width_p-1:0] current_tid_o,
    output logic                         issue_hold_o,
    output logic                         save_v_o,
    output logic [thread_id_width_p-1:0] save_tid_o,
    output logic                         redirect_v_o,
    output logic [vaddr_width_p-1:0]     redirect_npc_o,
    input  logic                         redirect_yumi_i,
    output logic                         switch_done_o,
    output logic                         drain_timeout_o
);

    bp_be_ctxt_sw_state_e         r_state, w_state_nxt;
    logic [thread_id_width_p-1:0] r_tid, w_tid_nxt;
    logic [thread_id_width_p-1:0] r_target, w_target_nxt;
    logic [quantum_width_p-1:0]   r_cnt, w_cnt_nxt;

    logic                         w_any_en, w_cur_en, w_csr_ok, w_expire;
    logic [quantum_width_p-1:0]   w_cnt_inc;
    logic [thread_id_width_p-1:0] w_pick_tid;
    logic                         w_pick_found;

    bp_be_ctxt_rr_pick #(
        .num_threads_p    (num_threads_p),
        .thread_id_width_p(thread_id_width_p)
    ) u_pick (
        .cur_tid_i (r_tid),
        .en_i      (thread_en_i),
        .next_tid_o(w_pick_tid),
        .found_o   (w_pick_found)
    );

    assign w_any_en  = |thread_en_i;
    assign w_cur_en  = thread_en_i[r_tid];
    assign w_csr_ok  = csr_switch_v_i && thread_en_i[csr_switch_tid_i];
    // A count already past quantum_i-1 (quantum shrank) counts as expired.
    assign w_expire  = (quantum_i != '0) && (r_cnt >= quantum_i - 1'b1);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef BP_BE_CTXT_DRAIN_TIMEOUT_EN
    localparam logic [drain_timeout_width_p-1:0] WD_LAST = {{(drain_timeout_width_p-1){1'b1}}, 1'b0};
    logic [drain_timeout_width_p-1:0] r_wd, w_wd_nxt;
    logic                             w_wd_fire;

    assign w_wd_fire = (r_state == e_drain) && !pipe_idle_i && (r_wd == WD_LAST);
    assign w_wd_nxt  = (r_state == e_drain && w_state_nxt == e_drain) ? r_wd + 1'b1 : '0;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_wd <= '0;
        else          r_wd <= w_wd_nxt;
    end
`endif

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt        = r_state;
        w_tid_nxt          = r_tid;
        w_target_nxt       = r_target;
        w_cnt_nxt          = r_cnt;
        csr_switch_ready_o = 1'b0;
        issue_hold_o       = 1'b1;
        save_v_o           = 1'b0;
        save_tid_o         = '0;
        redirect_v_o       = 1'b0;
        redirect_npc_o     = '0;
        switch_done_o      = 1'b0;
        drain_timeout_o    = 1'b0;
        case (r_state)
            e_run: begin
                csr_switch_ready_o = 1'b1;
                issue_hold_o       = !w_any_en;
                if (!w_any_en) begin
                    w_cnt_nxt = r_cnt;
                end else if (w_csr_ok) begin
                    if (csr_switch_tid_i == r_tid) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_target_nxt = csr_switch_tid_i;
                        w_state_nxt  = e_drain;
                    end
                end else if ((w_expire || !w_cur_en) && w_pick_found) begin
                    if (w_pick_tid == r_tid) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_target_nxt = w_pick_tid;
                        w_state_nxt  = e_drain;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            e_drain: begin
                if (pipe_idle_i) begin
                    w_state_nxt = e_save;
                end
`ifdef BP_BE_CTXT_DRAIN_TIMEOUT_EN
                else if (w_wd_fire) begin
                    drain_timeout_o = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = e_run;
                end
`endif
            end
            e_save: begin
                save_v_o    = 1'b1;
                save_tid_o  = r_tid;
                w_tid_nxt   = r_target;
                w_state_nxt = e_redirect;
            end
            e_redirect: begin
                // current_tid_o already names the incoming thread, so ctx_npc_i is its NPC.
                redirect_v_o   = 1'b1;
                redirect_npc_o = ctx_npc_i;
                if (redirect_yumi_i) w_state_nxt = e_resume;
            end
            e_resume: begin
                switch_done_o = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = e_run;
            end
            default: w_state_nxt = e_run;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= e_run;
            r_tid    <= '0;
            r_target <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tid    <= w_tid_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign current_tid_o = r_tid;

endmodule

// File: tb/tb_bp_be_ctxt_switch_ctrl.sv
// Scoreboard bench: stimulus queues expected switch events, a negedge monitor pops and compares.
module tb_bp_be_ctxt_switch_ctrl;

    localparam int NT = 4;
    localparam int TW = 2;
    localparam int VA = 39;
    localparam int QW = 16;

    localparam int EV_SAVE  = 0;
    localparam int EV_REDIR = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_TO    = 3;

    typedef struct {
        int          kind;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic [QW-1:0] quantum_i = '0;
    logic [NT-1:0] thread_en_i = 4'b1111;
    logic          csr_switch_v_i = 1'b0;
    logic [TW-1:0] csr_switch_tid_i = '0;
    logic          csr_switch_ready_o;
    logic          pipe_idle_i = 1'b1;
    logic [VA-1:0] ctx_npc_i;
    logic [TW-1:0] current_tid_o;
    logic          issue_hold_o;
    logic          save_v_o;
    logic [TW-1:0] save_tid_o;
    logic          redirect_v_o;
    logic [VA-1:0] redirect_npc_o;
    logic          redirect_yumi_i = 1'b1;
    logic          switch_done_o;
    logic          drain_timeout_o;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  base  = 0;
    ev_t sb[$];

    bp_be_ctxt_switch_ctrl #(
        .num_threads_p        (NT),
        .thread_id_width_p    (TW),
        .vaddr_width_p        (VA),
        .quantum_width_p      (QW)
`ifdef BP_BE_CTXT_DRAIN_TIMEOUT_EN
        , .drain_timeout_width_p(3)
`endif
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .quantum_i         (quantum_i),
        .thread_en_i       (thread_en_i),
        .csr_switch_v_i    (csr_switch_v_i),
        .csr_switch_tid_i  (csr_switch_tid_i),
        .csr_switch_ready_o(csr_switch_ready_o),
        .pipe_idle_i       (pipe_idle_i),
        .ctx_npc_i         (ctx_npc_i),
        .current_tid_o     (current_tid_o),
        .issue_hold_o      (issue_hold_o),
        .save_v_o          (save_v_o),
        .save_tid_o        (save_tid_o),
        .redirect_v_o      (redirect_v_o),
        .redirect_npc_o    (redirect_npc_o),
        .redirect_yumi_i   (redirect_yumi_i),
        .switch_done_o     (switch_done_o),
        .drain_timeout_o   (drain_timeout_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Context storage model: each thread's saved NPC is a fixed per-thread address.
    function automatic logic [VA-1:0] npc_of(input logic [TW-1:0] t);
        return 39'h40_0000_0000 | (39'(t) << 12);
    endfunction

    assign ctx_npc_i = npc_of(current_tid_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [63:0] data, input int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic mon_event(input int kind, input logic [63:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ev kind=%0d: got data %0h at cycle %0d, expected none", kind, data, cyc - base);
        end else begin
            e = sb.pop_front();
            check($sformatf("ev_kind@%0d", cyc - base), 64'(kind), 64'(e.kind));
            check($sformatf("ev%0d_data@%0d", kind, cyc - base), data, e.data);
            check($sformatf("ev%0d_cycle", kind), 64'(cyc - base), 64'(e.cyc));
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_i) begin
            if (save_v_o)                       mon_event(EV_SAVE, 64'(save_tid_o));
            if (redirect_v_o && redirect_yumi_i) mon_event(EV_REDIR, 64'(redirect_npc_o));
            if (switch_done_o)                  mon_event(EV_DONE, 64'(current_tid_o));
            if (drain_timeout_o)                mon_event(EV_TO, 64'(current_tid_o));
        end
    end

    task automatic do_reset(input logic [QW-1:0] q, input logic [NT-1:0] en, input logic idle, input logic yumi);
        reset_i          = 1'b0;
        quantum_i        = q;
        thread_en_i      = en;
        pipe_idle_i      = idle;
        redirect_yumi_i  = yumi;
        csr_switch_v_i   = 1'b0;
        csr_switch_tid_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        base    = cyc;
    endtask

    // Cycle k is the interval after the k-th rising edge since reset release.
    task automatic wait_to(input int k);
        while (cyc - base < k) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_drained(input string name, input logic [TW-1:0] tid);
        #1;
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_tid"}, 64'(current_tid_o), 64'(tid));
    endtask

    initial begin
        // Reset state
        reset_i = 1'b0;
        #2;
        check("rst_tid", 64'(current_tid_o), 64'd0);
        check("rst_ready", 64'(csr_switch_ready_o), 64'd1);
        check("rst_hold", 64'(issue_hold_o), 64'd0);
        check("rst_out", 64'({save_v_o, redirect_v_o, switch_done_o, drain_timeout_o}), 64'd0);

        // Timer round robin over all four threads
        do_reset(16'd4, 4'b1111, 1'b1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            expect_ev(EV_SAVE,  64'(n), 5 + 8 * n);
            expect_ev(EV_REDIR, 64'(npc_of(TW'((n + 1) % NT))), 6 + 8 * n);
            expect_ev(EV_DONE,  64'((n + 1) % NT), 7 + 8 * n);
        end
        wait_to(3);
        #1 check("t1_hold_run", 64'(issue_hold_o), 64'd0);
        wait_to(4);
        #1 check("t1_hold_drain", 64'(issue_hold_o), 64'd1);
        wait_to(32);
        quantum_i = '0;
        wait_to(40);
        check_drained("t1", 2'd0);

        // Sparse mask: only threads 0 and 2 run
        do_reset(16'd3, 4'b0101, 1'b1, 1'b1);
        expect_ev(EV_SAVE, 64'd0, 4);
        expect_ev(EV_REDIR, 64'(npc_of(2'd2)), 5);
        expect_ev(EV_DONE, 64'd2, 6);
        expect_ev(EV_SAVE, 64'd2, 11);
        expect_ev(EV_REDIR, 64'(npc_of(2'd0)), 12);
        expect_ev(EV_DONE, 64'd0, 13);
        wait_to(14);
        quantum_i = '0;
        wait_to(20);
        check_drained("t2", 2'd0);

        // CSR-requested switch, then a dropped request and the all-disabled case
        do_reset(16'd0, 4'b1111, 1'b1, 1'b1);
        expect_ev(EV_SAVE, 64'd0, 3);
        expect_ev(EV_REDIR, 64'(npc_of(2'd3)), 4);
        expect_ev(EV_DONE, 64'd3, 5);
        wait_to(1);
        csr_switch_v_i   = 1'b1;
        csr_switch_tid_i = 2'd3;
        #1 check("t3_ready_run", 64'(csr_switch_ready_o), 64'd1);
        wait_to(2);
        csr_switch_v_i = 1'b0;
        wait_to(3);
        #1 check("t3_ready_save", 64'(csr_switch_ready_o), 64'd0);
        wait_to(8);
        thread_en_i      = 4'b1101;
        csr_switch_v_i   = 1'b1;
        csr_switch_tid_i = 2'd1;
        wait_to(9);
        csr_switch_v_i = 1'b0;
        thread_en_i    = 4'b1111;
        wait_to(12);
        check_drained("t3", 2'd3);
        thread_en_i = 4'b0000;
        #1 check("t3_hold_alloff", 64'(issue_hold_o), 64'd1);
        wait_to(16);
        check("t3_tid_alloff", 64'(current_tid_o), 64'd3);
        thread_en_i = 4'b1111;
        #1 check("t3_hold_back", 64'(issue_hold_o), 64'd0);

        // Drain stall (and watchdog when enabled)
        do_reset(16'd2, 4'b1111, 1'b0, 1'b1);
`ifdef BP_BE_CTXT_DRAIN_TIMEOUT_EN
        expect_ev(EV_TO, 64'd0, 8);
        for (int k = 2; k <= 8; k++) begin
            wait_to(k);
            #1 check($sformatf("t4_hold@%0d", k), 64'(issue_hold_o), 64'd1);
        end
        quantum_i = '0;
        wait_to(20);
        check_drained("t4", 2'd0);
`else
        expect_ev(EV_SAVE, 64'd0, 13);
        expect_ev(EV_REDIR, 64'(npc_of(2'd1)), 14);
        expect_ev(EV_DONE, 64'd1, 15);
        for (int k = 2; k <= 11; k++) begin
            wait_to(k);
            #1 check($sformatf("t4_hold@%0d", k), 64'(issue_hold_o), 64'd1);
        end
        wait_to(12);
        pipe_idle_i = 1'b1;
        #1 check("t4_hold_idle", 64'(issue_hold_o), 64'd1);
        wait_to(16);
        quantum_i = '0;
        wait_to(20);
        check_drained("t4", 2'd1);
`endif

        // Delayed redirect acceptance
        do_reset(16'd2, 4'b1111, 1'b1, 1'b0);
        expect_ev(EV_SAVE, 64'd0, 3);
        expect_ev(EV_REDIR, 64'(npc_of(2'd1)), 9);
        expect_ev(EV_DONE, 64'd1, 10);
        for (int k = 4; k <= 8; k++) begin
            wait_to(k);
            #1;
            check($sformatf("t5_redir_v@%0d", k), 64'(redirect_v_o), 64'd1);
            check($sformatf("t5_redir_npc@%0d", k), 64'(redirect_npc_o), 64'(npc_of(2'd1)));
        end
        wait_to(9);
        redirect_yumi_i = 1'b1;
        wait_to(10);
        quantum_i = '0;
        wait_to(16);
        check_drained("t5", 2'd1);

        // Asynchronous reset in the middle of a redirect
        do_reset(16'd2, 4'b1111, 1'b1, 1'b0);
        expect_ev(EV_SAVE, 64'd0, 3);
        wait_to(5);
        #1 check("t6_in_redirect", 64'(redirect_v_o), 64'd1);
        reset_i = 1'b0;
        #1;
        check("t6_redir_v", 64'(redirect_v_o), 64'd0);
        check("t6_redir_npc", 64'(redirect_npc_o), 64'd0);
        check("t6_tid", 64'(current_tid_o), 64'd0);
        check("t6_hold", 64'(issue_hold_o), 64'd0);
        check("t6_ready", 64'(csr_switch_ready_o), 64'd1);
        check("t6_pulses", 64'({save_v_o, switch_done_o}), 64'd0);
        quantum_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        base    = cyc;
        wait_to(6);
        check_drained("t6", 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units, expected completion");
        $fatal(1);
    end

endmodule
